console_bus_interface: RTL and testbench
========================================

Name: console_bus_interface

Overview:
- Parametrised 6809 bus front end for the console. It replaces the purely combinational decode-and-steer top level with a clocked bus-cycle sequencer.
- Samples the CPU address on Q rising and decodes it into NUM_REGIONS programmable regions.
- Stretches the cycle through MRDY according to per-region wait-state counts.
- Controls data-bus direction and emits a single-cycle write strobe with latched data on E falling.
- Sits between the CPU pins and the SRAM, I/O and EEPROM blocks.

Parameters:
- ADDR_W, 16, CPU address width.
- DATA_W, 8, data bus width.
- NUM_REGIONS, 3, number of decoded regions.
- WAIT_W, 4, width of the per-region wait-state count.
- REGION_BASE, {16'hC000,16'h8000,16'h0000}, packed NUM_REGIONS*ADDR_W; region i base.
- REGION_MASK, {16'hC000,16'hF000,16'h8000}, packed NUM_REGIONS*ADDR_W; region i compare mask.
- REGION_WAIT, {4'd4,4'd2,4'd0}, packed NUM_REGIONS*WAIT_W; clk cycles of MRDY low for region i.
- TIMEOUT_CYCLES, 64, bus watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; must run at 4x E or faster.
- reset  in  1  synchronous, active-high reset.
- address_in  in  ADDR_W  CPU address.
- r_nw  in  1  CPU read/not-write.
- e  in  1  CPU E clock, asynchronous to clk.
- q  in  1  CPU Q clock, asynchronous to clk.
- bus_available  in  1  CPU BA; when high, the bus is not owned by the CPU.
- mrdy  out  1  memory ready to CPU; low stretches E.
- region_select  out  NUM_REGIONS  one-hot registered chip select.
- region_valid  out  1  the current cycle hit a region.
- data_oe  out  1  drive data_bus (CPU read from a hit region).
- rd_data  in  DATA_W  data returned by the selected slave.
- data_out  out  DATA_W  value to drive onto data_bus when data_oe is high.
- data_in  in  DATA_W  value sampled from data_bus.
- wr_strobe  out  1  one-clk write pulse to the selected slave.
- wr_data  out  DATA_W  data latched for the write.
- bus_error  out  1  one-clk watchdog pulse; tied 0 unless the feature is compiled in.

Behaviour:
- Synchronisation: e and q each pass through a 2-FF synchroniser plus edge detect. A synchronised edge is visible 3 clk after the pin edge.
- Decode: region i hits when (address_in & MASK_i) == BASE_i. On overlap, the lowest index wins. Address and r_nw are latched on the q_rise pulse.
- State machine: IDLE, DECODE, WAIT, ACTIVE.
  - IDLE -> DECODE on q_rise with bus_available=0. A q_rise with bus_available=1 is ignored and the FSM stays in IDLE.
  - DECODE (1 clk): register region_select and region_valid. Load the wait counter with REGION_WAIT of the hit region.
  - DECODE -> WAIT if the hit region's wait count is non-zero; otherwise DECODE -> ACTIVE. A miss always goes to ACTIVE.
  - WAIT: mrdy=0; decrement the counter each clk; go to ACTIVE when the counter reaches 1. MRDY is therefore low for exactly REGION_WAIT clk.
  - ACTIVE: mrdy=1. data_oe=1 iff r_nw=1 and region_valid=1; data_out follows rd_data combinationally.
  - ACTIVE -> IDLE on e_fall. If the cycle is a write and region_valid=1, pulse wr_strobe for 1 clk, with wr_data = data_in captured on that same clk.
- Miss cycle: region_select=0, data_oe=0, no wr_strobe; the cycle completes normally (open bus).
- A q_rise arriving while not in IDLE is ignored.
- Reset values: mrdy=1, region_select=0, region_valid=0, data_oe=0, wr_strobe=0, wr_data=0, bus_error=0, FSM=IDLE.
- Reset mid-cycle: all outputs return to reset values on the next clk; no strobe is issued.

Optional Feature:
- Macro: CONSOLE_BUS_TIMEOUT_EN.
- With the macro: a counter starts in DECODE. If e_fall is not seen within TIMEOUT_CYCLES clk, the block:
  - pulses bus_error for 1 clk,
  - forces mrdy=1 and data_oe=0,
  - returns to IDLE without wr_strobe.
- Without the macro: no counter is built, bus_error is constant 0, and ACTIVE waits for e_fall indefinitely.

Decomposition:
- Package console_bus_pkg holds:
  - the FSM state enum bus_state_t,
  - the default region base, mask and wait constants,
  - the region index width function.
- One sub-module, console_edge_sync: 2-FF synchroniser plus rise/fall pulse outputs. It is instantiated twice, for e and q.

Test Plan:
- Read 0x1234 (SRAM, 0 waits), rd_data=0xA5 -> region_select=3'b001; mrdy never low; data_oe=1 and data_out=0xA5 until e_fall.
- Write 0x8010 (IO, 2 waits), data_in=0x3C -> mrdy low exactly 2 clk; one wr_strobe with wr_data=0x3C; region_select=3'b010.
- Read 0xC000 (EEPROM, 4 waits) -> mrdy low exactly 4 clk, then data_oe=1.
- Access 0xA000 (no hit) -> region_valid=0, data_oe=0, no wr_strobe, mrdy stays 1.
- q pulse with bus_available=1 -> FSM stays IDLE and all outputs stay at reset values.
- Assert reset during WAIT of a 0x8010 write -> next clk mrdy=1 and region_select=0; no wr_strobe. With CONSOLE_BUS_TIMEOUT_EN and e held high 64 clk -> one bus_error pulse, FSM back in IDLE.

Source files
------------

// File: rtl/console_bus_pkg.sv
// console_bus_pkg
// Shared types and constants for the console 6809 bus front end.
//   bus_state_t         : bus-cycle sequencer states
//   DEFAULT_REGION_*    : default region map (index 0 in the LSB slice)
//                         region 0 = SRAM   0x0000-0x7FFF, 0 waits
//                         region 1 = I/O    0x8000-0x8FFF, 2 waits
//                         region 2 = EEPROM 0xC000-0xFFFF, 4 waits
//   region_idx_w()      : bit width needed to hold a region index
package console_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACTIVE
    } bus_state_t;

    localparam int DEFAULT_ADDR_W      = 16;
    localparam int DEFAULT_WAIT_W      = 4;
    localparam int DEFAULT_NUM_REGIONS = 3;

    localparam logic [DEFAULT_NUM_REGIONS*DEFAULT_ADDR_W-1:0] DEFAULT_REGION_BASE =
        {16'hC000, 16'h8000, 16'h0000};
    localparam logic [DEFAULT_NUM_REGIONS*DEFAULT_ADDR_W-1:0] DEFAULT_REGION_MASK =
        {16'hC000, 16'hF000, 16'h8000};
    localparam logic [DEFAULT_NUM_REGIONS*DEFAULT_WAIT_W-1:0] DEFAULT_REGION_WAIT =
        {4'd4, 4'd2, 4'd0};

    // A single region still needs a one-bit index so the decode logic stays uniform.
    function automatic int region_idx_w(input int num_regions);
        return (num_regions > 1) ? $clog2(num_regions) : 1;
    endfunction

endpackage

// File: rtl/console_bus_interface_edge_sync.sv
// console_edge_sync
// Two-flop synchroniser for an asynchronous CPU clock pin followed by an
// edge detector.  The rise/fall pulses are registered, so a pin edge shows up
// as a one-clk pulse three clk edges after the pin changed.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   async_in in  asynchronous pin (E or Q)
//   rise     out one-clk pulse on a synchronised rising edge
//   fall     out one-clk pulse on a synchronised falling edge
module console_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic sync_d;

    // meta_q may go metastable; only sync_q and its delayed copy feed logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            sync_d <= sync_q;
            rise   <= sync_q & ~sync_d;
            fall   <= ~sync_q & sync_d;
        end
    end

endmodule

// File: rtl/console_bus_interface.sv
// console_bus_interface
// Clocked 6809 bus-cycle sequencer for the console.  Latches the CPU address
// on Q rising, decodes it into NUM_REGIONS programmable regions, stretches E
// through MRDY for the region's wait-state count, steers the data bus and
// issues a one-clk write strobe with latched data on E falling.
// Optional feature macro: CONSOLE_BUS_TIMEOUT_EN (bus watchdog -> bus_error).
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   address_in, r_nw    CPU address and read/not-write
//   e, q                CPU E and Q clocks (asynchronous to clk)
//   bus_available       CPU BA; high means the CPU does not own the bus
//   mrdy                memory ready; low stretches E
//   region_select       one-hot registered chip select
//   region_valid        current cycle hit a region
//   data_oe, data_out   drive data_bus with data_out (read from a hit region)
//   rd_data             data returned by the selected slave
//   data_in             value sampled from data_bus
//   wr_strobe, wr_data  one-clk write pulse and its latched data
//   bus_error           one-clk watchdog pulse (0 without the feature)
module console_bus_interface
    import console_bus_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int NUM_REGIONS    = 3,
    parameter int WAIT_W         = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = DEFAULT_REGION_WAIT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      address_in,
    input  logic                   r_nw,
    input  logic                   e,
    input  logic                   q,
    input  logic                   bus_available,
    output logic                   mrdy,
    output logic [NUM_REGIONS-1:0] region_select,
    output logic                   region_valid,
    output logic                   data_oe,
    input  logic [DATA_W-1:0]      rd_data,
    output logic [DATA_W-1:0]      data_out,
    input  logic [DATA_W-1:0]      data_in,
    output logic                   wr_strobe,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   bus_error
);

    localparam int IDX_W = region_idx_w(NUM_REGIONS);

    logic e_rise, e_fall;
    logic q_rise, q_fall;

    console_edge_sync u_e_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (e),
        .rise     (e_rise),
        .fall     (e_fall)
    );

    console_edge_sync u_q_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (q),
        .rise     (q_rise),
        .fall     (q_fall)
    );

    // Only E falling and Q rising mark bus-cycle boundaries.
    logic unused_edges;
    assign unused_edges = e_rise ^ q_fall;

    bus_state_t        state;
    logic [ADDR_W-1:0] addr_lat;
    logic              rnw_lat;
    logic [WAIT_W-1:0] wait_cnt;

    logic                   hit_any;
    logic [IDX_W-1:0]       hit_idx;
    logic [NUM_REGIONS-1:0] hit_onehot;
    logic [WAIT_W-1:0]      hit_wait;

    // Scan from the highest index down so the lowest matching region is the
    // last one written and therefore wins on overlap.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        hit_wait   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr_lat & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        if (hit_any) begin
            hit_onehot = NUM_REGIONS'(1) << hit_idx;
            hit_wait   = REGION_WAIT[int'(hit_idx)*WAIT_W +: WAIT_W];
        end
    end

    // The slave's read data is passed straight through; data_oe gates the pins.
    assign data_out = rd_data;

`ifdef CONSOLE_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] timeout_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign bus_error = 1'b0;
`endif

    // Bus-cycle sequencer.  MRDY drops on the DECODE edge and the counter is
    // loaded with the wait count, so leaving WAIT when the counter reads 1
    // keeps MRDY low for exactly that many clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_lat      <= '0;
            rnw_lat       <= 1'b1;
            wait_cnt      <= '0;
            mrdy          <= 1'b1;
            region_select <= '0;
            region_valid  <= 1'b0;
            data_oe       <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_data       <= '0;
`ifdef CONSOLE_BUS_TIMEOUT_EN
            bus_error     <= 1'b0;
            timeout_cnt   <= '0;
`endif
        end else begin
            wr_strobe <= 1'b0;
`ifdef CONSOLE_BUS_TIMEOUT_EN
            bus_error <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (q_rise && !bus_available) begin
                        addr_lat <= address_in;
                        rnw_lat  <= r_nw;
                        state    <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    region_select <= hit_onehot;
                    region_valid  <= hit_any;
                    wait_cnt      <= hit_wait;
`ifdef CONSOLE_BUS_TIMEOUT_EN
                    timeout_cnt   <= TO_W'(1);
`endif
                    if (hit_any && (hit_wait != '0)) begin
                        mrdy  <= 1'b0;
                        state <= ST_WAIT;
                    end else begin
                        data_oe <= rnw_lat & hit_any;
                        state   <= ST_ACTIVE;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        mrdy    <= 1'b1;
                        data_oe <= rnw_lat & region_valid;
                        state   <= ST_ACTIVE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                ST_ACTIVE: begin
                    if (e_fall) begin
                        data_oe       <= 1'b0;
                        region_select <= '0;
                        region_valid  <= 1'b0;
                        state         <= ST_IDLE;
                        if (!rnw_lat && region_valid) begin
                            wr_strobe <= 1'b1;
                            wr_data   <= data_in;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase

`ifdef CONSOLE_BUS_TIMEOUT_EN
            // The watchdog overrides whatever the sequencer chose this clk,
            // except on the clk where the cycle completes normally.
            if ((state == ST_WAIT) || ((state == ST_ACTIVE) && !e_fall)) begin
                if (timeout_cnt >= TO_W'(TIMEOUT_CYCLES)) begin
                    bus_error     <= 1'b1;
                    mrdy          <= 1'b1;
                    data_oe       <= 1'b0;
                    wr_strobe     <= 1'b0;
                    region_select <= '0;
                    region_valid  <= 1'b0;
                    state         <= ST_IDLE;
                end else begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_console_bus_interface.sv
// tb_console_bus_interface
// Self-checking bench for console_bus_interface: reset values, a table of
// directed bus cycles, randomized cycles against a region-range model, and
// hand-written sequences for reset during WAIT and (with
// CONSOLE_BUS_TIMEOUT_EN) the bus watchdog.
module tb_console_bus_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_in;
    logic        r_nw;
    logic        e;
    logic        q;
    logic        bus_available;
    logic        mrdy;
    logic [2:0]  region_select;
    logic        region_valid;
    logic        data_oe;
    logic [7:0]  rd_data;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        wr_strobe;
    logic [7:0]  wr_data;
    logic        bus_error;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    console_bus_interface dut (
        .clk           (clk),
        .reset         (reset),
        .address_in    (address_in),
        .r_nw          (r_nw),
        .e             (e),
        .q             (q),
        .bus_available (bus_available),
        .mrdy          (mrdy),
        .region_select (region_select),
        .region_valid  (region_valid),
        .data_oe       (data_oe),
        .rd_data       (rd_data),
        .data_out      (data_out),
        .data_in       (data_in),
        .wr_strobe     (wr_strobe),
        .wr_data       (wr_data),
        .bus_error     (bus_error)
    );

    // Everything observed on the outputs over one bus cycle.
    typedef struct {
        logic [2:0] sel_seen;
        logic       valid_seen;
        int         mrdy_low;
        int         mrdy_runs;
        logic       prev_mrdy;
        logic       oe_in_wait;
        logic       oe_active;
        logic [7:0] dout_active;
        int         strobes;
        logic [7:0] wr_data_seen;
        logic       oe_after;
        int         errors;
    } meas_t;

    typedef struct {
        logic [15:0] addr;
        logic        rnw;
        logic        ba;
        logic [7:0]  rd;
        logic [7:0]  din;
        logic        req;
        logic [2:0]  esel;
        logic        evalid;
        int          ewaits;
        logic        eoe;
        int          estrobes;
    } vec_t;

    function automatic meas_t newMeas();
        meas_t m;
        m.sel_seen     = '0;
        m.valid_seen   = 1'b0;
        m.mrdy_low     = 0;
        m.mrdy_runs    = 0;
        m.prev_mrdy    = 1'b1;
        m.oe_in_wait   = 1'b0;
        m.oe_active    = 1'b0;
        m.dout_active  = '0;
        m.strobes      = 0;
        m.wr_data_seen = '0;
        m.oe_after     = 1'b0;
        m.errors       = 0;
        return m;
    endfunction

    // Reference map from the region ranges: lowest index has priority.
    function automatic int modelRegion(input logic [15:0] a);
        if (a <= 16'h7FFF) return 0;
        if (a >= 16'h8000 && a <= 16'h8FFF) return 1;
        if (a >= 16'hC000) return 2;
        return -1;
    endfunction

    function automatic int modelWaits(input int region);
        int waits[3] = '{0, 2, 4};
        return (region < 0) ? 0 : waits[region];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic observe(input int n, inout meas_t m);
        repeat (n) begin
            @(negedge clk);
            m.sel_seen   |= region_select;
            m.valid_seen |= region_valid;
            if (bus_error) m.errors++;
            if (!mrdy) begin
                m.mrdy_low++;
                if (m.prev_mrdy) m.mrdy_runs++;
                if (data_oe) m.oe_in_wait = 1'b1;
            end
            m.prev_mrdy = mrdy;
            if (wr_strobe) begin
                m.strobes++;
                m.wr_data_seen = wr_data;
            end
        end
    endtask

    // One complete CPU bus cycle; req re-raises Q mid-cycle.
    task automatic applyStimulus(input logic [15:0] a, input logic rnw, input logic ba,
                                 input logic [7:0] rd, input logic [7:0] din, input logic req,
                                 output meas_t m);
        m = newMeas();
        @(negedge clk);
        address_in    = a;
        r_nw          = rnw;
        bus_available = ba;
        rd_data       = rd;
        data_in       = din;
        q             = 1'b1;
        observe(2, m);
        e = 1'b1;
        if (req) begin
            observe(2, m);
            q = 1'b0;
            observe(2, m);
            q = 1'b1;
            observe(14, m);
        end else begin
            observe(18, m);
        end
        m.oe_active   = data_oe;
        m.dout_active = data_out;
        q = 1'b0;
        e = 1'b0;
        observe(8, m);
        m.oe_after = data_oe;
        data_in = ~din;
        observe(4, m);
        bus_available = 1'b0;
    endtask

    task automatic checkCycle(input string tag, input meas_t m, input logic [2:0] esel,
                              input logic evalid, input int ewaits, input logic eoe,
                              input logic [7:0] erd, input int estrobes, input logic [7:0] ewd);
        checkOutput({tag, ".sel"}, m.sel_seen, esel);
        checkOutput({tag, ".valid"}, m.valid_seen, evalid);
        checkOutput({tag, ".mrdy_low"}, m.mrdy_low, ewaits);
        checkOutput({tag, ".mrdy_runs"}, m.mrdy_runs, (ewaits > 0) ? 1 : 0);
        checkOutput({tag, ".oe_in_wait"}, m.oe_in_wait, 1'b0);
        checkOutput({tag, ".oe_active"}, m.oe_active, eoe);
        if (eoe) checkOutput({tag, ".data_out"}, m.dout_active, erd);
        checkOutput({tag, ".strobes"}, m.strobes, estrobes);
        if (estrobes > 0) checkOutput({tag, ".wr_data"}, m.wr_data_seen, ewd);
        checkOutput({tag, ".oe_after"}, m.oe_after, 1'b0);
        checkOutput({tag, ".bus_error"}, m.errors, 0);
    endtask

    initial begin
        vec_t  vecs[$];
        meas_t m;

        reset         = 1'b1;
        address_in    = '0;
        r_nw          = 1'b1;
        e             = 1'b0;
        q             = 1'b0;
        bus_available = 1'b0;
        rd_data       = '0;
        data_in       = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst.mrdy", mrdy, 1'b1);
        checkOutput("rst.sel", region_select, 3'b000);
        checkOutput("rst.valid", region_valid, 1'b0);
        checkOutput("rst.oe", data_oe, 1'b0);
        checkOutput("rst.strobe", wr_strobe, 1'b0);
        checkOutput("rst.wr_data", wr_data, 8'h00);
        checkOutput("rst.bus_error", bus_error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // addr, rnw, ba, rd, din, req, esel, evalid, ewaits, eoe, estrobes
        vecs.push_back('{16'h1234, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{16'h1234, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 3'b001, 1'b1, 0, 1'b1, 0});
        vecs.push_back('{16'h8010, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 3'b010, 1'b1, 2, 1'b0, 1});
        vecs.push_back('{16'hC000, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 3'b100, 1'b1, 4, 1'b1, 0});
        vecs.push_back('{16'hA000, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{16'hA000, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{16'h7FFF, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0, 3'b001, 1'b1, 0, 1'b0, 1});
        vecs.push_back('{16'h8FFF, 1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 3'b010, 1'b1, 2, 1'b1, 0});
        vecs.push_back('{16'h9000, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{16'hBFFF, 1'b0, 1'b0, 8'h00, 8'h66, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{16'hFFFF, 1'b0, 1'b0, 8'h00, 8'hE7, 1'b0, 3'b100, 1'b1, 4, 1'b0, 1});
        vecs.push_back('{16'hC123, 1'b1, 1'b0, 8'h3E, 8'h00, 1'b1, 3'b100, 1'b1, 4, 1'b1, 0});
        vecs.push_back('{16'h8000, 1'b0, 1'b1, 8'h00, 8'h12, 1'b0, 3'b000, 1'b0, 0, 1'b0, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].rnw, vecs[i].ba, vecs[i].rd, vecs[i].din, vecs[i].req, m);
            checkCycle($sformatf("vec%0d", i), m, vecs[i].esel, vecs[i].evalid, vecs[i].ewaits,
                       vecs[i].eoe, vecs[i].rd, vecs[i].estrobes, vecs[i].din);
        end

        // Randomized cycles against the range model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            logic        rnw;
            logic        ba;
            logic [7:0]  rd;
            logic [7:0]  din;
            int          reg_idx;
            logic        hit;
            a       = 16'($urandom);
            rnw     = 1'($urandom);
            ba      = ($urandom_range(0, 7) == 0);
            rd      = 8'($urandom);
            din     = 8'($urandom);
            reg_idx = ba ? -1 : modelRegion(a);
            hit     = (reg_idx >= 0);
            applyStimulus(a, rnw, ba, rd, din, 1'b0, m);
            checkCycle($sformatf("rnd%0d", n), m,
                       hit ? 3'(1 << reg_idx) : 3'b000, hit, modelWaits(reg_idx),
                       hit && rnw, rd, (hit && !rnw) ? 1 : 0, din);
        end

        // Reset while a 0x8010 write is stretched in WAIT.
        begin
            bit seen_wait = 0;
            @(negedge clk);
            address_in    = 16'h8010;
            r_nw          = 1'b0;
            bus_available = 1'b0;
            data_in       = 8'h3C;
            q             = 1'b1;
            for (int k = 0; k < 20 && !seen_wait; k++) begin
                @(negedge clk);
                if (k == 1) e = 1'b1;
                if (!mrdy) seen_wait = 1;
            end
            checkOutput("rstwait.reached_wait", seen_wait, 1'b1);
            reset = 1'b1;
            @(negedge clk);
            checkOutput("rstwait.mrdy", mrdy, 1'b1);
            checkOutput("rstwait.sel", region_select, 3'b000);
            checkOutput("rstwait.valid", region_valid, 1'b0);
            checkOutput("rstwait.oe", data_oe, 1'b0);
            checkOutput("rstwait.wr_data", wr_data, 8'h00);
            q = 1'b0;
            e = 1'b0;
            m = newMeas();
            observe(3, m);
            reset = 1'b0;
            observe(10, m);
            checkOutput("rstwait.strobes", m.strobes, 0);
            checkOutput("rstwait.mrdy_low", m.mrdy_low, 0);
            checkOutput("rstwait.sel_after", m.sel_seen, 3'b000);
        end

`ifdef CONSOLE_BUS_TIMEOUT_EN
        // E held high: the watchdog ends the cycle with one bus_error pulse.
        begin
            m = newMeas();
            @(negedge clk);
            address_in = 16'h1234;
            r_nw       = 1'b1;
            rd_data    = 8'h5A;
            q          = 1'b1;
            e          = 1'b1;
            observe(90, m);
            checkOutput("timeout.errors", m.errors, 1);
            checkOutput("timeout.mrdy", mrdy, 1'b1);
            checkOutput("timeout.oe", data_oe, 1'b0);
            checkOutput("timeout.sel", region_select, 3'b000);
            q = 1'b0;
            e = 1'b0;
            observe(10, m);
            checkOutput("timeout.strobes", m.strobes, 0);
            applyStimulus(16'h8010, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, m);
            checkCycle("timeout.next", m, 3'b010, 1'b1, 2, 1'b0, 8'h00, 1, 8'h3C);
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
